// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: owns the PC and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
// Optional single-step parking in IDLE is enabled by defining MULTICYCLE_CTRL_SINGLE_STEP_EN.
module multicycle_ctrl #(
  parameter int PC_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      opcode,
  input  logic            zero,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] jump_target,
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] instr_addr,
  output logic            ir_write,
  output logic            alu_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            busy,
  output logic            done,
  output logic [2:0]      state_dbg
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALTED = 3'd6;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd1;
  localparam logic [2:0] OP_SW   = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_BEQ  = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [PC_W-1:0] PC_ZERO = {PC_W{1'b0}};
  localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

  // Where an instruction goes once it retires: straight to the next fetch, or parked in IDLE.
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
  localparam logic [2:0] ST_RET = ST_IDLE;
  logic step_s;
  assign step_s = step;
`else
  localparam logic [2:0] ST_RET = ST_FETCH;
  logic step_s;
  assign step_s = 1'b0;
`endif

  logic [2:0]      state_r;
  logic [2:0]      next_state_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_next_s;
  logic [2:0]      op_r;
  logic [2:0]      op_next_s;

  // State, program counter and latched opcode registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      pc_r    <= PC_ZERO;
      op_r    <= OP_NOP;
    end else begin
      state_r <= next_state_s;
      pc_r    <= pc_next_s;
      op_r    <= op_next_s;
    end
  end

  // Next-state, next-PC and opcode-latch decode.
  always_comb begin
    next_state_s = state_r;
    pc_next_s    = pc_r;
    op_next_s    = op_r;
    case (state_r)
      ST_IDLE: begin
        if (start || step_s) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        pc_next_s    = pc_r + PC_ONE;
        next_state_s = ST_DECODE;
      end
      ST_DECODE: begin
        op_next_s = opcode;
        case (opcode)
          OP_NOP:  next_state_s = ST_RET;
          OP_JMP: begin
            pc_next_s    = jump_target;
            next_state_s = ST_RET;
          end
          OP_HALT: next_state_s = ST_HALTED;
          default: next_state_s = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (op_r)
          OP_ADD, OP_ADDI: next_state_s = ST_WB;
          OP_LW, OP_SW:    next_state_s = ST_MEM;
          OP_BEQ: begin
            if (zero) begin
              pc_next_s = branch_target;
            end else begin
              pc_next_s = pc_r;
            end
            next_state_s = ST_RET;
          end
          default: next_state_s = ST_RET;
        endcase
      end
      ST_MEM: begin
        if (op_r == OP_LW) begin
          next_state_s = ST_WB;
        end else begin
          next_state_s = ST_RET;
        end
      end
      ST_WB: next_state_s = ST_RET;
      ST_HALTED: begin
        if (start) begin
          pc_next_s    = PC_ZERO;
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_HALTED;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Moore strobe decode; reset clears the state so strobes drop asynchronously.
  always_comb begin
    ir_write  = 1'b0;
    alu_src   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_r)
      ST_IDLE: busy = 1'b0;
      ST_FETCH: begin
        ir_write = 1'b1;
        busy     = 1'b1;
      end
      ST_DECODE: busy = 1'b1;
      ST_EXEC: begin
        alu_src = (op_r == OP_LW) || (op_r == OP_SW) || (op_r == OP_ADDI);
        busy    = 1'b1;
      end
      ST_MEM: begin
        alu_src   = (op_r == OP_LW) || (op_r == OP_SW) || (op_r == OP_ADDI);
        mem_read  = (op_r == OP_LW);
        mem_write = (op_r == OP_SW);
        busy      = 1'b1;
      end
      ST_WB: begin
        reg_write = 1'b1;
        busy      = 1'b1;
      end
      ST_HALTED: done = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  assign instr_addr = pc_r;
  assign state_dbg  = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl; the single-step sequence is used when
// MULTICYCLE_CTRL_SINGLE_STEP_EN is defined.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] branch_target;
  logic [2:0] jump_target;
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
  logic       step;
`endif
  logic [2:0] instr_addr;
  logic       ir_write;
  logic       alu_src;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  int vectors;
  int miscompares;

  // {ir_write, alu_src, mem_read, mem_write, reg_write, busy, done}
  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_FETCH  = 7'b1000010;
  localparam logic [6:0] O_BUSY   = 7'b0000010;
  localparam logic [6:0] O_EXIMM  = 7'b0100010;
  localparam logic [6:0] O_MEMSW  = 7'b0101010;
  localparam logic [6:0] O_MEMLW  = 7'b0110010;
  localparam logic [6:0] O_WB     = 7'b0000110;
  localparam logic [6:0] O_HALTED = 7'b0000001;

  multicycle_ctrl #(.PC_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .opcode        (opcode),
    .zero          (zero),
    .branch_target (branch_target),
    .jump_target   (jump_target),
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
    .step          (step),
`endif
    .instr_addr    (instr_addr),
    .ir_write      (ir_write),
    .alu_src       (alu_src),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .busy          (busy),
    .done          (done),
    .state_dbg     (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] exp_state, input logic [2:0] exp_pc,
                     input logic [6:0] exp_out);
    logic [6:0] outs;
    outs = {ir_write, alu_src, mem_read, mem_write, reg_write, busy, done};
    vectors++;
    assert (state_dbg === exp_state)
      else begin miscompares++; $error("FAIL %s state: got %0d expected %0d", tag, state_dbg, exp_state); end
    vectors++;
    assert (instr_addr === exp_pc)
      else begin miscompares++; $error("FAIL %s pc: got %0d expected %0d", tag, instr_addr, exp_pc); end
    vectors++;
    assert (outs === exp_out)
      else begin miscompares++; $error("FAIL %s strobes: got %b expected %b", tag, outs, exp_out); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b0; opcode = 3'd0; zero = 1'b0;
    branch_target = 3'd0; jump_target = 3'd0;
`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
    step = 1'b0;
`endif
    cyc(); cyc();
    chk("reset", 3'd0, 3'd0, O_IDLE);
    rst = 1'b0;
    cyc();
    chk("idle_wait", 3'd0, 3'd0, O_IDLE);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_fetch", 3'd1, 3'd0, O_FETCH);

`ifdef MULTICYCLE_CTRL_SINGLE_STEP_EN
    opcode = 3'd3;
    cyc(); chk("ss_add1_dec", 3'd2, 3'd1, O_BUSY);
    cyc(); chk("ss_add1_exec", 3'd3, 3'd1, O_BUSY);
    cyc(); chk("ss_add1_wb", 3'd5, 3'd1, O_WB);
    cyc(); chk("ss_park1", 3'd0, 3'd1, O_IDLE);
    cyc(); chk("ss_park1_hold", 3'd0, 3'd1, O_IDLE);
    step = 1'b1;
    cyc(); step = 1'b0;
    chk("ss_step_fetch", 3'd1, 3'd1, O_FETCH);
    cyc(); chk("ss_add2_dec", 3'd2, 3'd2, O_BUSY);
    cyc(); chk("ss_add2_exec", 3'd3, 3'd2, O_BUSY);
    cyc(); chk("ss_add2_wb", 3'd5, 3'd2, O_WB);
    cyc(); chk("ss_park2", 3'd0, 3'd2, O_IDLE);
    step = 1'b1;
    cyc(); step = 1'b0;
    chk("ss_step_fetch2", 3'd1, 3'd2, O_FETCH);
`else
    // ADDI, SW, LW, HALT from PC 0
    opcode = 3'd4;
    cyc(); chk("addi_dec", 3'd2, 3'd1, O_BUSY);
    cyc(); chk("addi_exec", 3'd3, 3'd1, O_EXIMM);
    cyc(); chk("addi_wb", 3'd5, 3'd1, O_WB);
    cyc(); chk("sw_fetch", 3'd1, 3'd1, O_FETCH);
    opcode = 3'd2;
    cyc(); chk("sw_dec", 3'd2, 3'd2, O_BUSY);
    cyc(); chk("sw_exec", 3'd3, 3'd2, O_EXIMM);
    cyc(); chk("sw_mem", 3'd4, 3'd2, O_MEMSW);
    cyc(); chk("lw_fetch", 3'd1, 3'd2, O_FETCH);
    opcode = 3'd1;
    cyc(); chk("lw_dec", 3'd2, 3'd3, O_BUSY);
    cyc(); chk("lw_exec", 3'd3, 3'd3, O_EXIMM);
    cyc(); chk("lw_mem", 3'd4, 3'd3, O_MEMLW);
    cyc(); chk("lw_wb", 3'd5, 3'd3, O_WB);
    cyc(); chk("halt_fetch", 3'd1, 3'd3, O_FETCH);
    opcode = 3'd7;
    cyc(); chk("halt_dec", 3'd2, 3'd4, O_BUSY);
    cyc(); chk("halted", 3'd6, 3'd4, O_HALTED);
    cyc(); chk("halted_hold", 3'd6, 3'd4, O_HALTED);

    start = 1'b1;
    cyc(); start = 1'b0;
    chk("restart_fetch", 3'd1, 3'd0, O_FETCH);

    // two NOPs to reach PC 2, then BEQ taken
    opcode = 3'd0;
    cyc(); chk("nop0_dec", 3'd2, 3'd1, O_BUSY);
    cyc(); chk("nop1_fetch", 3'd1, 3'd1, O_FETCH);
    cyc(); chk("nop1_dec", 3'd2, 3'd2, O_BUSY);
    cyc(); chk("beq_fetch", 3'd1, 3'd2, O_FETCH);
    opcode = 3'd5; zero = 1'b1; branch_target = 3'd6;
    cyc(); chk("beq_dec", 3'd2, 3'd3, O_BUSY);
    start = 1'b1;
    cyc(); chk("beq_exec", 3'd3, 3'd3, O_BUSY);
    cyc(); start = 1'b0;
    chk("beq_taken", 3'd1, 3'd6, O_FETCH);

    opcode = 3'd6; jump_target = 3'd2;
    cyc(); chk("jmp2_dec", 3'd2, 3'd7, O_BUSY);
    cyc(); chk("jmp2_fetch", 3'd1, 3'd2, O_FETCH);
    opcode = 3'd5; zero = 1'b0;
    cyc(); chk("beqnt_dec", 3'd2, 3'd3, O_BUSY);
    cyc(); chk("beqnt_exec", 3'd3, 3'd3, O_BUSY);
    cyc(); chk("beq_not_taken", 3'd1, 3'd3, O_FETCH);

    opcode = 3'd6; jump_target = 3'd7;
    cyc(); chk("jmp7_dec", 3'd2, 3'd4, O_BUSY);
    cyc(); chk("jmp7_fetch", 3'd1, 3'd7, O_FETCH);
    jump_target = 3'd1;
    cyc(); chk("jmp_at7_dec", 3'd2, 3'd0, O_BUSY);
    cyc(); chk("jmp_at7_fetch", 3'd1, 3'd1, O_FETCH);
    jump_target = 3'd7;
    cyc(); chk("jmp7b_dec", 3'd2, 3'd2, O_BUSY);
    cyc(); chk("jmp7b_fetch", 3'd1, 3'd7, O_FETCH);
    opcode = 3'd0;
    cyc(); chk("nop_wrap_dec", 3'd2, 3'd0, O_BUSY);
    cyc(); chk("nop_wrap_fetch", 3'd1, 3'd0, O_FETCH);

    // tight loop: JMP to its own address
    opcode = 3'd6; jump_target = 3'd0;
    cyc(); chk("loop_dec", 3'd2, 3'd1, O_BUSY);
    cyc(); chk("loop_fetch", 3'd1, 3'd0, O_FETCH);

    // ADD with start held during busy: no alu_src, start ignored
    opcode = 3'd3; start = 1'b1;
    cyc(); chk("add_dec", 3'd2, 3'd1, O_BUSY);
    cyc(); chk("add_exec", 3'd3, 3'd1, O_BUSY);
    cyc(); chk("add_wb", 3'd5, 3'd1, O_WB);
    cyc(); start = 1'b0;
    chk("add_next_fetch", 3'd1, 3'd1, O_FETCH);

    // reset asserted mid-MEM of SW
    opcode = 3'd2;
    cyc(); chk("sw2_dec", 3'd2, 3'd2, O_BUSY);
    cyc(); chk("sw2_exec", 3'd3, 3'd2, O_EXIMM);
    cyc(); chk("sw2_mem", 3'd4, 3'd2, O_MEMSW);
    #2 rst = 1'b1;
    #1 chk("async_reset", 3'd0, 3'd0, O_IDLE);
    cyc();
    rst = 1'b0;
    cyc(); chk("post_reset_idle", 3'd0, 3'd0, O_IDLE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
